// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and RAM-port bundle between the FIFO controller and its producer/consumer.
// The master side issues requests; the controller (slave) drives RAM controls and status.
interface sync_fifo_ctrl_if #(
   parameter int WIDTH_ADDR = 8
);
   logic                  i_wr_req;
   logic                  i_rd_req;
   logic                  i_clr_err;
   logic                  o_ram_wr_en;
   logic [WIDTH_ADDR-1:0] o_ram_waddr;
   logic                  o_ram_rd_en;
   logic [WIDTH_ADDR-1:0] o_ram_raddr;
   logic                  o_rd_valid;
   logic                  o_full;
   logic                  o_empty;
   logic                  o_almost_full;
   logic                  o_almost_empty;
   logic [WIDTH_ADDR:0]   o_count;
   logic                  o_overflow;
   logic                  o_underflow;

   modport master (
      output i_wr_req, i_rd_req, i_clr_err,
      input  o_ram_wr_en, o_ram_waddr, o_ram_rd_en, o_ram_raddr, o_rd_valid,
             o_full, o_empty, o_almost_full, o_almost_empty, o_count,
             o_overflow, o_underflow
   );

   modport slave (
      input  i_wr_req, i_rd_req, i_clr_err,
      output o_ram_wr_en, o_ram_waddr, o_ram_rd_en, o_ram_raddr, o_rd_valid,
             o_full, o_empty, o_almost_full, o_almost_empty, o_count,
             o_overflow, o_underflow
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller for a single-clock FIFO in front of a dual-port RAM with
// registered read data; tracks occupancy, threshold flags and sticky error status.
module sync_fifo_ctrl #(
   parameter int WIDTH_ADDR = 8,
   parameter int AF_THRESH  = 240,
   parameter int AE_THRESH  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   sync_fifo_ctrl_if.slave   bus
);
   localparam int PW = WIDTH_ADDR + 1;
   localparam logic [WIDTH_ADDR:0] AF_C  = PW'(AF_THRESH);
   localparam logic [WIDTH_ADDR:0] AE_C  = PW'(AE_THRESH);
   localparam logic [WIDTH_ADDR:0] ONE_C = PW'(1);

   logic [WIDTH_ADDR:0] wptr_r;
   logic [WIDTH_ADDR:0] rptr_r;
   logic [WIDTH_ADDR:0] count_r;
   logic [WIDTH_ADDR:0] count_nxt_s;
   logic                rd_valid_r;
   logic                overflow_r;
   logic                underflow_r;
   logic                overflow_nxt_s;
   logic                underflow_nxt_s;
   logic                full_s;
   logic                empty_s;
   logic                wr_acc_s;
   logic                rd_acc_s;

   // Wrap bit distinguishes full from empty when the address bits coincide.
   assign empty_s  = (wptr_r == rptr_r);
   assign full_s   = (wptr_r[WIDTH_ADDR] != rptr_r[WIDTH_ADDR]) &&
                     (wptr_r[WIDTH_ADDR-1:0] == rptr_r[WIDTH_ADDR-1:0]);
   assign wr_acc_s = bus.i_wr_req & ~full_s  & i_rst_n;
   assign rd_acc_s = bus.i_rd_req & ~empty_s & i_rst_n;

   // Next occupancy and sticky error state; a set in the same cycle beats a clear.
   always_comb begin
      count_nxt_s     = count_r;
      overflow_nxt_s  = overflow_r;
      underflow_nxt_s = underflow_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_nxt_s = count_r + ONE_C;
         2'b01:   count_nxt_s = count_r - ONE_C;
         default: count_nxt_s = count_r;
      endcase
      if (bus.i_wr_req && full_s) begin
         overflow_nxt_s = 1'b1;
      end else if (bus.i_clr_err) begin
         overflow_nxt_s = 1'b0;
      end else begin
         overflow_nxt_s = overflow_r;
      end
      if (bus.i_rd_req && empty_s) begin
         underflow_nxt_s = 1'b1;
      end else if (bus.i_clr_err) begin
         underflow_nxt_s = 1'b0;
      end else begin
         underflow_nxt_s = underflow_r;
      end
   end

   // Pointer, count, read-valid and error registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wptr_r      <= {PW{1'b0}};
         rptr_r      <= {PW{1'b0}};
         count_r     <= {PW{1'b0}};
         rd_valid_r  <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wptr_r <= wptr_r + ONE_C;
         end
         if (rd_acc_s) begin
            rptr_r <= rptr_r + ONE_C;
         end
         count_r     <= count_nxt_s;
         rd_valid_r  <= rd_acc_s;
         overflow_r  <= overflow_nxt_s;
         underflow_r <= underflow_nxt_s;
      end
   end

   assign bus.o_ram_wr_en    = wr_acc_s;
   assign bus.o_ram_waddr    = wptr_r[WIDTH_ADDR-1:0];
   assign bus.o_ram_rd_en    = rd_acc_s;
   assign bus.o_ram_raddr    = rptr_r[WIDTH_ADDR-1:0];
   assign bus.o_rd_valid     = rd_valid_r;
   assign bus.o_full         = full_s;
   assign bus.o_empty        = empty_s;
   assign bus.o_almost_full  = (count_r >= AF_C);
   assign bus.o_almost_empty = (count_r <= AE_C);
   assign bus.o_count        = count_r;
   assign bus.o_overflow     = overflow_r;
   assign bus.o_underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a behavioural RAM plus a queue-based FIFO model predict
// every controller output each cycle under directed and randomized traffic.
module tb_sync_fifo_ctrl;
   localparam int WA    = 8;
   localparam int DEPTH = 256;
   localparam int AF    = 240;
   localparam int AE    = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] mem [DEPTH];
   logic [31:0] rdata = 32'd0;

   sync_fifo_ctrl_if #(.WIDTH_ADDR(WA)) bus ();

   sync_fifo_ctrl #(.WIDTH_ADDR(WA), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Dual-port RAM with registered read data.
   always @(posedge clk) begin
      if (bus.o_ram_wr_en) mem[bus.o_ram_waddr] <= wdata;
      if (bus.o_ram_rd_en) rdata <= mem[bus.o_ram_raddr];
   end

   logic [31:0] q [$];
   int unsigned nw, nr;
   bit          ov, un, exp_rv;
   logic [31:0] exp_rdata;
   int          n_total = 0;
   int          n_pass  = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      q.delete();
      nw = 0; nr = 0; ov = 1'b0; un = 1'b0; exp_rv = 1'b0;
   endtask

   task automatic check_outputs(bit wr, bit rd);
      int sz;
      sz = q.size();
      chk("wr_en",     32'(bus.o_ram_wr_en),    32'(wr && sz < DEPTH));
      chk("rd_en",     32'(bus.o_ram_rd_en),    32'(rd && sz > 0));
      chk("waddr",     32'(bus.o_ram_waddr),    nw % DEPTH);
      chk("raddr",     32'(bus.o_ram_raddr),    nr % DEPTH);
      chk("full",      32'(bus.o_full),         32'(sz == DEPTH));
      chk("empty",     32'(bus.o_empty),        32'(sz == 0));
      chk("afull",     32'(bus.o_almost_full),  32'(sz >= AF));
      chk("aempty",    32'(bus.o_almost_empty), 32'(sz <= AE));
      chk("count",     32'(bus.o_count),        32'(sz));
      chk("rd_valid",  32'(bus.o_rd_valid),     32'(exp_rv));
      chk("overflow",  32'(bus.o_overflow),     32'(ov));
      chk("underflow", 32'(bus.o_underflow),    32'(un));
      if (exp_rv) chk("rdata", rdata, exp_rdata);
   endtask

   task automatic step(bit wr, bit rd, bit clr);
      bit wa, ra;
      int sz;
      @(negedge clk);
      bus.i_wr_req  = wr;
      bus.i_rd_req  = rd;
      bus.i_clr_err = clr;
      wdata         = $urandom;
      #1;
      check_outputs(wr, rd);
      sz = q.size();
      wa = wr && (sz < DEPTH);
      ra = rd && (sz > 0);
      @(posedge clk);
      #1;
      ov     = (wr && sz == DEPTH) ? 1'b1 : (clr ? 1'b0 : ov);
      un     = (rd && sz == 0)     ? 1'b1 : (clr ? 1'b0 : un);
      exp_rv = ra;
      if (ra) begin
         exp_rdata = q.pop_front();
         nr++;
      end
      if (wa) begin
         q.push_back(wdata);
         nw++;
      end
   endtask

   initial begin
      bus.i_wr_req  = 1'b0;
      bus.i_rd_req  = 1'b0;
      bus.i_clr_err = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state, then fill to full with an overflow attempt and clear.
      step(1'b0, 1'b0, 1'b0);
      repeat (256) step(1'b1, 1'b0, 1'b0);
      #1;
      chk("full_at_256", 32'(bus.o_full), 32'd1);
      chk("count_256", 32'(bus.o_count), 32'd256);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk("ovf_cleared", 32'(bus.o_overflow), 32'd0);

      // Drain completely, then one read too many.
      repeat (256) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("empty_after_drain", 32'(bus.o_empty), 32'd1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);

      // Steady occupancy of 100 with simultaneous traffic across the address wrap.
      repeat (100) step(1'b1, 1'b0, 1'b0);
      repeat (300) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("count_steady_100", 32'(bus.o_count), 32'd100);

      // Full with both requests: only the read goes through.
      repeat (156) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("full_both_count", 32'(bus.o_count), 32'd255);

      // Empty with both requests: only the write goes through.
      repeat (255) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("empty_both_count", 32'(bus.o_count), 32'd1);
      step(1'b0, 1'b1, 1'b0);

      // Underflow set and clear in the same cycle: set holds, clears next cycle.
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk("unf_cleared", 32'(bus.o_underflow), 32'd0);

      // Asynchronous reset in the middle of a read burst.
      repeat (10) step(1'b1, 1'b0, 1'b0);
      repeat (3)  step(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      bus.i_wr_req = 1'b1;
      bus.i_rd_req = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_count",    32'(bus.o_count),     32'd0);
      chk("rst_empty",    32'(bus.o_empty),     32'd1);
      chk("rst_rd_valid", 32'(bus.o_rd_valid),  32'd0);
      chk("rst_wr_en",    32'(bus.o_ram_wr_en), 32'd0);
      chk("rst_rd_en",    32'(bus.o_ram_rd_en), 32'd0);
      model_reset();
      bus.i_wr_req = 1'b0;
      bus.i_rd_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Randomized traffic with alternating fill/drain bias.
      for (int i = 0; i < 2000; i++) begin
         int pw;
         pw = ((i / 250) % 2 == 0) ? 75 : 25;
         step($urandom_range(99) < pw,
              $urandom_range(99) < (100 - pw),
              $urandom_range(15) == 0);
      end
      step(1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Pointer/flag controller for the synchronous FIFO. It sits directly upstream of the dual-port RAM and drives its write and read ports on a single shared clock. It accepts write/read requests from the producer and consumer, generates RAM addresses and enables, and reports full/empty/almost/count and error status. It also produces a read-valid strobe aligned with the RAM's registered read data.

Parameters:
WIDTH_ADDR, 8, RAM address width; FIFO depth DEPTH = 2**WIDTH_ADDR (256)
AF_THRESH, 240, o_almost_full asserted when count >= AF_THRESH (range 1..DEPTH)
AE_THRESH, 16, o_almost_empty asserted when count <= AE_THRESH (range 0..DEPTH-1)

Ports:
i_clk  input  1  single clock for controller and both RAM ports (drives RAM i_wclk and i_rdclk)
i_rst_n  input  1  asynchronous, active-low reset
i_wr_req  input  1  producer write request
i_rd_req  input  1  consumer read request
i_clr_err  input  1  synchronous clear of sticky error flags
o_ram_wr_en  output  1  to RAM i_wr_en
o_ram_waddr  output  WIDTH_ADDR  to RAM i_WADDR
o_ram_rd_en  output  1  to RAM i_rd_en
o_ram_raddr  output  WIDTH_ADDR  to RAM i_RADDR
o_rd_valid  output  1  RAM o_RDATA holds the accepted read word this cycle
o_full  output  1  count == DEPTH
o_empty  output  1  count == 0
o_almost_full  output  1  count >= AF_THRESH
o_almost_empty  output  1  count <= AE_THRESH
o_count  output  WIDTH_ADDR+1  current occupancy, 0..DEPTH
o_overflow  output  1  sticky: write requested while full
o_underflow  output  1  sticky: read requested while empty

Behaviour:
- Single clock i_clk. Reset asynchronous, active-low (i_rst_n); all state updates on posedge i_clk.
- Reset values:
  - wptr = rptr = 0, count = 0
  - o_empty = 1, o_almost_empty = 1 (AE_THRESH >= 0)
  - o_full = 0, o_almost_full = 0
  - o_rd_valid = 0, o_overflow = 0, o_underflow = 0
  - o_ram_wr_en and o_ram_rd_en follow the accept rules below, so they are 0 during reset.
- Pointers wptr and rptr are WIDTH_ADDR+1 bits wide; the MSB is the wrap bit. o_ram_waddr = wptr[WIDTH_ADDR-1:0]; o_ram_raddr = rptr[WIDTH_ADDR-1:0].
- Write accept: wr_acc = i_wr_req & ~o_full & i_rst_n (combinational).
  - o_ram_wr_en = wr_acc. On wr_acc, wptr increments at the clock edge.
- Read accept: rd_acc = i_rd_req & ~o_empty & i_rst_n (combinational).
  - o_ram_rd_en = rd_acc. On rd_acc, rptr increments at the clock edge.
- Accept decisions use the current-cycle flags only:
  - Full with both requests: read accepted, write rejected.
  - Empty with both requests: write accepted, read rejected.
- Count update (registered): +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - Invariant: o_count == wptr - rptr (modulo 2**(WIDTH_ADDR+1)).
- Flags are combinational decodes of registered count and pointers, valid in the cycle after the causing edge.
  - o_empty = (wptr == rptr).
  - o_full = (wptr[MSB] != rptr[MSB]) && (low bits equal).
  - Both must agree with count at all times.
- Wrap-around: pointer increments past 2**(WIDTH_ADDR+1)-1 wrap to 0. Address 255 -> 0 with the wrap bit toggling.
- Read latency: the RAM registers data on rd_en. o_rd_valid is a register set to rd_acc, so it is high exactly 1 cycle after each accepted read, coincident with the word on RAM o_RDATA. Back-to-back reads produce back-to-back valids.
- Errors:
  - o_overflow sets on (i_wr_req & o_full); o_underflow sets on (i_rd_req & o_empty).
  - Both are sticky until i_clr_err=1 at a clock edge or reset.
  - If set and clear occur in the same cycle, set wins.
  - Rejected requests never modify pointers or count.
- Reset mid-operation: everything returns to reset values immediately (async) and FIFO contents are discarded logically. RAM contents are not cleared. o_rd_valid drops immediately.

Test Plan:
- Reset release, no requests -> o_empty=1, o_full=0, o_count=0, o_almost_empty=1, o_rd_valid=0, no RAM enables.
- 256 consecutive writes -> waddr 0..255; after the 240th write o_almost_full=1; after the 256th o_full=1, o_count=256. A 257th write -> o_ram_wr_en=0, o_overflow=1, count stays 256. i_clr_err -> o_overflow=0.
- From full, 256 consecutive reads -> raddr 0..255, o_rd_valid high cycles 1..256 after the first read, RAM data matches write order. o_almost_empty rises when count reaches 16; o_empty=1 at the end. An extra read -> o_underflow=1, o_ram_rd_en=0.
- Count 100, simultaneous wr+rd for 300 cycles -> count stays 100, both addresses wrap 255->0, data order preserved. When full, wr+rd -> only the read accepted, count 255. When empty, wr+rd -> only the write accepted, count 1.
- Write 10 words, then assert i_rst_n=0 mid-read burst -> o_count=0, o_empty=1, o_rd_valid=0 asynchronously. After release, the next write goes to address 0.
- Underflow set and i_clr_err asserted in the same cycle -> o_underflow remains 1; clears on the next cycle's i_clr_err with no read request.
